// File: rtl/fifo_ctl_mc.sv
// fifo_ctl_mc: command and response FIFOs shared between CPU-side channels
// and one PL-side port. Every request input runs its own IDLE/WAIT/ACK
// handshake. Command pops are served round-robin across channels, and a
// per-channel credit count stops a channel from issuing more commands than
// its response FIFO can hold.

// Request/acknowledge handshake. An operation fires exactly once for each
// rising edge of req.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   HS_IDLE | waiting for a fresh rising edge of req
//   HS_WAIT | edge seen; fire is asserted the first cycle enable is true
//   HS_ACK  | operation done; ack held high until req drops
module hs_fsm (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic enable,
    output logic fire,
    output logic ack
);
    typedef enum logic [1:0] {HS_IDLE, HS_WAIT, HS_ACK} hs_state_t;

    hs_state_t state;
    logic      req_q;

    assign fire = (state == HS_WAIT) && enable;

    // req_q is loaded during reset as well, so a req held high through
    // reset is not taken as a new edge once reset releases.
    always_ff @(posedge clk) begin
        req_q <= req;
        if (reset) begin
            state <= HS_IDLE;
            ack   <= 1'b0;
        end else begin
            case (state)
                HS_IDLE: if (req && !req_q) state <= HS_WAIT;
                HS_WAIT: if (enable) begin
                    state <= HS_ACK;
                    ack   <= 1'b1;
                end
                HS_ACK: if (!req) begin
                    state <= HS_IDLE;
                    ack   <= 1'b0;
                end
                default: begin
                    state <= HS_IDLE;
                    ack   <= 1'b0;
                end
            endcase
        end
    end
endmodule

module fifo_ctl_mc #(
    parameter  int NUM_CH     = 2,
    parameter  int CMD_DEPTH  = 4,
    parameter  int RESP_DEPTH = 4,
    parameter  int CMD_W      = 32,
    parameter  int RESP_W     = 32,
    localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OW         = $clog2(RESP_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          cmd_push_req,
    input  logic [NUM_CH*CMD_W-1:0]    cmd_push_data,
    output logic [NUM_CH-1:0]          cmd_push_ack,
    input  logic                       cmd_pop_req,
    output logic [CMD_W-1:0]           cmd_pop_data,
    output logic [CHW-1:0]             cmd_pop_ch,
    output logic                       cmd_pop_ack,
    input  logic                       resp_push_req,
    input  logic [CHW-1:0]             resp_push_ch,
    input  logic [RESP_W-1:0]          resp_push_data,
    output logic                       resp_push_ack,
    input  logic [NUM_CH-1:0]          resp_pop_req,
    output logic [NUM_CH*RESP_W-1:0]   resp_pop_data,
    output logic [NUM_CH-1:0]          resp_pop_ack,
    output logic [NUM_CH-1:0]          resp_pop_ready,
    output logic [NUM_CH*OW-1:0]       outstanding,
    output logic                       resp_err
);
    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int RPW = $clog2(RESP_DEPTH);

    logic [NUM_CH-1:0] cmd_push_en;
    logic [NUM_CH-1:0] cmd_ne;
    logic [NUM_CH-1:0] resp_full;
    logic [NUM_CH-1:0] out_zero;
    logic [CMD_W-1:0]  cmd_head [NUM_CH];

    logic              cmd_pop_en;
    logic              cmd_pop_fire;
    logic [CHW-1:0]    pop_sel;
    logic [CHW-1:0]    lo_sel;
    logic              hi_found;
    logic [NUM_CH-1:0] ne_shift;
    logic [CHW-1:0]    rr_ptr;

    logic              resp_push_en;
    logic              resp_push_fire;
    logic              resp_ch_ok;
    logic              resp_keep;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CMD_W-1:0]  c_mem [CMD_DEPTH];
        logic [CPW-1:0]    c_wr;
        logic [CPW-1:0]    c_rd;
        logic [CPW:0]      c_cnt;
        logic [RESP_W-1:0] r_mem [RESP_DEPTH];
        logic [RPW-1:0]    r_wr;
        logic [RPW-1:0]    r_rd;
        logic [RPW:0]      r_cnt;
        logic [OW-1:0]     o_cnt;
        logic [RESP_W-1:0] r_data_q;
        logic              c_push;
        logic              c_pop;
        logic              r_push;
        logic              r_pop;

        assign c_pop  = cmd_pop_fire && (pop_sel == CHW'(c));
        assign r_push = resp_push_fire && resp_keep && (resp_push_ch == CHW'(c));

        assign cmd_push_en[c]    = (c_cnt != (CPW+1)'(CMD_DEPTH)) && (o_cnt < OW'(RESP_DEPTH));
        assign cmd_ne[c]         = (c_cnt != '0);
        assign cmd_head[c]       = c_mem[c_rd];
        assign resp_full[c]      = (r_cnt == (RPW+1)'(RESP_DEPTH));
        assign out_zero[c]       = (o_cnt == '0);
        assign resp_pop_ready[c] = (r_cnt != '0);
        assign outstanding[c*OW +: OW]        = o_cnt;
        assign resp_pop_data[c*RESP_W +: RESP_W] = r_data_q;

        hs_fsm u_cmd_push (
            .clk    (clk),
            .reset  (reset),
            .req    (cmd_push_req[c]),
            .enable (cmd_push_en[c]),
            .fire   (c_push),
            .ack    (cmd_push_ack[c])
        );

        hs_fsm u_resp_pop (
            .clk    (clk),
            .reset  (reset),
            .req    (resp_pop_req[c]),
            .enable (resp_pop_ready[c]),
            .fire   (r_pop),
            .ack    (resp_pop_ack[c])
        );

        // Command FIFO: push and pop may land in the same cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                c_wr  <= '0;
                c_rd  <= '0;
                c_cnt <= '0;
            end else begin
                if (c_push) begin
                    c_mem[c_wr] <= cmd_push_data[c*CMD_W +: CMD_W];
                    c_wr        <= c_wr + 1'b1;
                end
                if (c_pop) c_rd <= c_rd + 1'b1;
                c_cnt <= c_cnt + (CPW+1)'(c_push) - (CPW+1)'(c_pop);
            end
        end

        // Response FIFO; the popped entry is held until the next pop.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr     <= '0;
                r_rd     <= '0;
                r_cnt    <= '0;
                r_data_q <= '0;
            end else begin
                if (r_push) begin
                    r_mem[r_wr] <= resp_push_data;
                    r_wr        <= r_wr + 1'b1;
                end
                if (r_pop) begin
                    r_data_q <= r_mem[r_rd];
                    r_rd     <= r_rd + 1'b1;
                end
                r_cnt <= r_cnt + (RPW+1)'(r_push) - (RPW+1)'(r_pop);
            end
        end

        // Credit count: one per issued command, returned when the CPU
        // consumes the response.
        always_ff @(posedge clk) begin
            if (reset) o_cnt <= '0;
            else       o_cnt <= o_cnt + OW'(c_push) - OW'(r_pop);
        end
    end

    assign cmd_pop_en = |cmd_ne;

    hs_fsm u_cmd_pop (
        .clk    (clk),
        .reset  (reset),
        .req    (cmd_pop_req),
        .enable (cmd_pop_en),
        .fire   (cmd_pop_fire),
        .ack    (cmd_pop_ack)
    );

    // Round-robin pick: the lowest non-empty channel at or above rr_ptr,
    // otherwise the lowest non-empty channel below it (wrap-around).
    always_comb begin
        pop_sel  = '0;
        lo_sel   = '0;
        hi_found = 1'b0;
        ne_shift = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            ne_shift = cmd_ne >> j;
            if (ne_shift[0]) begin
                if (CHW'(j) >= rr_ptr) begin
                    pop_sel  = CHW'(j);
                    hi_found = 1'b1;
                end else begin
                    lo_sel = CHW'(j);
                end
            end
        end
        if (!hi_found) pop_sel = lo_sel;
    end

    // Register the popped command and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            cmd_pop_data <= '0;
            cmd_pop_ch   <= '0;
        end else if (cmd_pop_fire) begin
            cmd_pop_data <= cmd_head[pop_sel];
            cmd_pop_ch   <= pop_sel;
            rr_ptr       <= (pop_sel == CHW'(NUM_CH - 1)) ? '0 : pop_sel + 1'b1;
        end
    end

    // Channel numbers beyond NUM_CH have no FIFO and never hold credit, so
    // they are acknowledged and dropped like any other uncredited response.
    assign resp_ch_ok   = ({1'b0, resp_push_ch} < (CHW+1)'(NUM_CH));
    assign resp_push_en = !resp_ch_ok || !resp_full[resp_push_ch];
    assign resp_keep    = resp_ch_ok && !out_zero[resp_push_ch];

    hs_fsm u_resp_push (
        .clk    (clk),
        .reset  (reset),
        .req    (resp_push_req),
        .enable (resp_push_en),
        .fire   (resp_push_fire),
        .ack    (resp_push_ack)
    );

    // Sticky flag for responses that arrived with no command outstanding.
    always_ff @(posedge clk) begin
        if (reset)                            resp_err <= 1'b0;
        else if (resp_push_fire && !resp_keep) resp_err <= 1'b1;
    end
endmodule

// File: tb/tb_fifo_ctl_mc.sv
// Directed bench for fifo_ctl_mc with its default parameters (2 channels,
// depth 4, 32-bit entries).
module tb_fifo_ctl_mc;
    localparam int CW = 32;
    localparam int RW = 32;
    localparam int OW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd_push_req;
    logic [63:0] cmd_push_data;
    logic [1:0]  cmd_push_ack;
    logic        cmd_pop_req;
    logic [31:0] cmd_pop_data;
    logic [0:0]  cmd_pop_ch;
    logic        cmd_pop_ack;
    logic        resp_push_req;
    logic [0:0]  resp_push_ch;
    logic [31:0] resp_push_data;
    logic        resp_push_ack;
    logic [1:0]  resp_pop_req;
    logic [63:0] resp_pop_data;
    logic [1:0]  resp_pop_ack;
    logic [1:0]  resp_pop_ready;
    logic [5:0]  outstanding;
    logic        resp_err;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_ctl_mc dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_push_req   (cmd_push_req),
        .cmd_push_data  (cmd_push_data),
        .cmd_push_ack   (cmd_push_ack),
        .cmd_pop_req    (cmd_pop_req),
        .cmd_pop_data   (cmd_pop_data),
        .cmd_pop_ch     (cmd_pop_ch),
        .cmd_pop_ack    (cmd_pop_ack),
        .resp_push_req  (resp_push_req),
        .resp_push_ch   (resp_push_ch),
        .resp_push_data (resp_push_data),
        .resp_push_ack  (resp_push_ack),
        .resp_pop_req   (resp_pop_req),
        .resp_pop_data  (resp_pop_data),
        .resp_pop_ack   (resp_pop_ack),
        .resp_pop_ready (resp_pop_ready),
        .outstanding    (outstanding),
        .resp_err       (resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic logic [31:0] outs(input int ch);
        return 32'(outstanding[ch*OW +: OW]);
    endfunction

    task automatic cmd_push(input int ch, input logic [31:0] d, input string tag);
        cmd_push_data[ch*CW +: CW] = d;
        cmd_push_req[ch] = 1'b1;
        for (int k = 0; k < 20 && !cmd_push_ack[ch]; k++) tick();
        chk(tag, 32'(cmd_push_ack[ch]), 32'd1);
        cmd_push_req[ch] = 1'b0;
        tick();
    endtask

    task automatic cmd_pop(input logic [31:0] exp_d, input logic [31:0] exp_ch, input string tag);
        cmd_pop_req = 1'b1;
        for (int k = 0; k < 20 && !cmd_pop_ack; k++) tick();
        chk({tag, "_ack"}, 32'(cmd_pop_ack), 32'd1);
        chk({tag, "_data"}, cmd_pop_data, exp_d);
        chk({tag, "_ch"}, 32'(cmd_pop_ch), exp_ch);
        cmd_pop_req = 1'b0;
        tick();
    endtask

    task automatic resp_push(input int ch, input logic [31:0] d, input string tag);
        resp_push_ch   = 1'(ch);
        resp_push_data = d;
        resp_push_req  = 1'b1;
        for (int k = 0; k < 20 && !resp_push_ack; k++) tick();
        chk(tag, 32'(resp_push_ack), 32'd1);
        resp_push_req = 1'b0;
        tick();
    endtask

    task automatic resp_pop(input int ch, input logic [31:0] exp_d, input string tag);
        resp_pop_req[ch] = 1'b1;
        for (int k = 0; k < 20 && !resp_pop_ack[ch]; k++) tick();
        chk({tag, "_ack"}, 32'(resp_pop_ack[ch]), 32'd1);
        chk({tag, "_data"}, resp_pop_data[ch*RW +: RW], exp_d);
        resp_pop_req[ch] = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hi;
        reset          = 1'b1;
        cmd_push_req   = '0;
        cmd_push_data  = '0;
        cmd_pop_req    = 1'b0;
        resp_push_req  = 1'b0;
        resp_push_ch   = '0;
        resp_push_data = '0;
        resp_pop_req   = '0;
        repeat (3) tick();
        reset = 1'b0;

        // reset state
        chk("rst_push_ack", 32'(cmd_push_ack), 32'd0);
        chk("rst_pop_ack", 32'(cmd_pop_ack), 32'd0);
        chk("rst_rpush_ack", 32'(resp_push_ack), 32'd0);
        chk("rst_ready", 32'(resp_pop_ready), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_pop_data", cmd_pop_data, 32'd0);

        // round-robin command pops across two channels
        cmd_push(0, 32'hA1, "t1_push_a1");
        cmd_push(0, 32'hA2, "t1_push_a2");
        cmd_push(1, 32'hB1, "t1_push_b1");
        chk("t1_out0", outs(0), 32'd2);
        chk("t1_out1", outs(1), 32'd1);
        cmd_pop(32'hA1, 32'd0, "t1_pop1");
        cmd_pop(32'hB1, 32'd1, "t1_pop2");
        cmd_pop(32'hA2, 32'd0, "t1_pop3");

        // responses return credit only when the CPU pops them
        resp_push(1, 32'hC1, "t2_rpush_c1");
        chk("t2_ready1", 32'(resp_pop_ready[1]), 32'd1);
        chk("t2_out1_held", outs(1), 32'd1);
        resp_pop(1, 32'hC1, "t2_rpop_c1");
        chk("t2_out1", outs(1), 32'd0);
        resp_push(0, 32'hD0, "t2_rpush_d0");
        resp_push(0, 32'hD1, "t2_rpush_d1");
        resp_pop(0, 32'hD0, "t2_rpop_d0");
        resp_pop(0, 32'hD1, "t2_rpop_d1");
        chk("t2_out0", outs(0), 32'd0);

        // response for a channel with nothing outstanding
        chk("t3_err_before", 32'(resp_err), 32'd0);
        resp_push(1, 32'hBAD, "t3_rpush_uncredited");
        chk("t3_ready1", 32'(resp_pop_ready[1]), 32'd0);
        chk("t3_err", 32'(resp_err), 32'd1);

        // push and pop firing together on a one-entry FIFO
        cmd_push(0, 32'hE1, "t4_push_e1");
        cmd_push_data[0 +: CW] = 32'hE2;
        cmd_push_req[0] = 1'b1;
        cmd_pop_req     = 1'b1;
        for (int k = 0; k < 20 && !cmd_push_ack[0] && !cmd_pop_ack; k++) tick();
        chk("t4_same_cycle", {30'd0, cmd_push_ack[0], cmd_pop_ack}, 32'd3);
        chk("t4_pop_data", cmd_pop_data, 32'hE1);
        chk("t4_pop_ch", 32'(cmd_pop_ch), 32'd0);
        cmd_push_req[0] = 1'b0;
        cmd_pop_req     = 1'b0;
        tick();
        cmd_pop(32'hE2, 32'd0, "t4_pop_e2");
        cmd_pop_req = 1'b1;
        repeat (5) tick();
        chk("t4_empty_no_ack", 32'(cmd_pop_ack), 32'd0);
        cmd_push(1, 32'hF1, "t4_push_f1");
        for (int k = 0; k < 20 && !cmd_pop_ack; k++) tick();
        chk("t4_late_pop_ack", 32'(cmd_pop_ack), 32'd1);
        chk("t4_late_pop_data", cmd_pop_data, 32'hF1);
        chk("t4_late_pop_ch", 32'(cmd_pop_ch), 32'd1);
        cmd_pop_req = 1'b0;
        tick();
        chk("t4_out0", outs(0), 32'd2);
        chk("t4_out1", outs(1), 32'd1);

        // req held high for ten cycles: one fire, ack from the second edge
        cmd_push_data[CW +: CW] = 32'h61;
        cmd_push_req[1] = 1'b1;
        n_hi = 0;
        tick();
        chk("t5_ack_edge1", 32'(cmd_push_ack[1]), 32'd0);
        for (int k = 2; k <= 10; k++) begin
            tick();
            if (k == 2) chk("t5_ack_edge2", 32'(cmd_push_ack[1]), 32'd1);
            if (cmd_push_ack[1]) n_hi++;
        end
        chk("t5_ack_cycles", 32'(n_hi), 32'd9);
        cmd_push_req[1] = 1'b0;
        tick();
        chk("t5_ack_fall", 32'(cmd_push_ack[1]), 32'd0);
        chk("t5_out1_once", outs(1), 32'd2);

        // credit limit on ch0
        cmd_push(0, 32'h71, "t6_push3");
        cmd_push(0, 32'h72, "t6_push4");
        chk("t6_out0_full", outs(0), 32'd4);
        cmd_push_data[0 +: CW] = 32'h73;
        cmd_push_req[0] = 1'b1;
        repeat (8) tick();
        chk("t6_push5_blocked", 32'(cmd_push_ack[0]), 32'd0);
        chk("t6_out0_still4", outs(0), 32'd4);
        resp_push(0, 32'h5A, "t6_rpush");
        resp_pop(0, 32'h5A, "t6_rpop");
        for (int k = 0; k < 20 && !cmd_push_ack[0]; k++) tick();
        chk("t6_push5_fires", 32'(cmd_push_ack[0]), 32'd1);
        cmd_push_req[0] = 1'b0;
        tick();
        chk("t6_out0_after", outs(0), 32'd4);
        cmd_pop(32'h71, 32'd0, "t6_pop1");
        cmd_pop(32'h61, 32'd1, "t6_pop2");
        cmd_pop(32'h72, 32'd0, "t6_pop3");
        cmd_pop(32'h73, 32'd0, "t6_pop4");

        // reset while a push sits in WAIT; req kept high across reset
        cmd_push_data[0 +: CW] = 32'h81;
        cmd_push_req[0] = 1'b1;
        repeat (3) tick();
        chk("t7_wait_no_ack", 32'(cmd_push_ack[0]), 32'd0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("t7_rst_out", 32'(outstanding), 32'd0);
        chk("t7_rst_ack", 32'(cmd_push_ack), 32'd0);
        chk("t7_rst_err", 32'(resp_err), 32'd0);
        chk("t7_rst_pop_data", cmd_pop_data, 32'd0);
        chk("t7_rst_pop_ch", 32'(cmd_pop_ch), 32'd0);
        repeat (6) tick();
        chk("t7_held_no_ack", 32'(cmd_push_ack[0]), 32'd0);
        chk("t7_held_no_fire", 32'(outstanding), 32'd0);
        cmd_pop_req = 1'b1;
        repeat (4) tick();
        chk("t7_fifo_empty", 32'(cmd_pop_ack), 32'd0);
        cmd_push_req[0] = 1'b0;
        tick();
        cmd_push(0, 32'h82, "t7_repush");
        for (int k = 0; k < 20 && !cmd_pop_ack; k++) tick();
        chk("t7_pop_ack", 32'(cmd_pop_ack), 32'd1);
        chk("t7_pop_data", cmd_pop_data, 32'h82);
        chk("t7_pop_ch", 32'(cmd_pop_ch), 32'd0);
        cmd_pop_req = 1'b0;
        tick();
        chk("t7_out0", outs(0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_ctl_mc.md
FIFO_CTL_MC -- requirements
Module: fifo_ctl_mc

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent CPU-side channels (1..8).
REQ-002 Parameter CMD_DEPTH, default 4, entries per channel command FIFO (power of 2, >=2).
REQ-003 Parameter RESP_DEPTH, default 4, entries per channel response FIFO (power of 2, >=2).
REQ-004 Parameter CMD_W, default 32, and RESP_W, default 32, shall set the entry widths; CHW=max(1,clog2(NUM_CH)).
REQ-005 The block shall use one clock; reset is synchronous and active-high.
REQ-006 Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_push_req  in  NUM_CH  per-channel CPU push request
- cmd_push_data  in  NUM_CH*CMD_W  per-channel command, channel c at [c*CMD_W +: CMD_W]
- cmd_push_ack  out  NUM_CH  per-channel push acknowledge
- cmd_pop_req  in  1  PL pop request
- cmd_pop_data  out  CMD_W  popped command
- cmd_pop_ch  out  CHW  channel of popped command
- cmd_pop_ack  out  1  PL pop acknowledge
- resp_push_req  in  1  PL response push request
- resp_push_ch  in  CHW  target channel of response
- resp_push_data  in  RESP_W  response
- resp_push_ack  out  1  response push acknowledge
- resp_pop_req  in  NUM_CH  per-channel CPU pop request
- resp_pop_data  out  NUM_CH*RESP_W  per-channel popped response
- resp_pop_ack  out  NUM_CH  per-channel pop acknowledge
- resp_pop_ready  out  NUM_CH  response FIFO of channel non-empty
- outstanding  out  NUM_CH*(clog2(RESP_DEPTH)+1)  per-channel credit count
- resp_err  out  1  sticky: response for channel with zero outstanding

Function
REQ-007 Every req input shall have its own handshake FSM IDLE/WAIT/ACK; IDLE->WAIT on registered rising edge (req=1, prior-cycle req=0).
REQ-008 WAIT: when enable true, the operation fires this cycle (one-cycle internal pulse) and FSM->ACK; when enable false, FSM stays in WAIT indefinitely.
REQ-009 ACK: ack=1; stays until req=0, then ->IDLE with ack=0 next cycle; req held high never fires a second operation.
REQ-010 Latency: req rises at edge N, earliest fire in cycle N+1, ack high from edge N+2.
REQ-011 cmd push enable(c) = cmd FIFO c not full AND outstanding(c) < RESP_DEPTH; data sampled in fire cycle.
REQ-012 cmd pop enable = any cmd FIFO non-empty; channel chosen round-robin starting at (last served + 1) mod NUM_CH; after reset, search starts at channel 0.
REQ-013 cmd_pop_data/cmd_pop_ch shall register head entry and chosen channel at fire edge and hold stable until next cmd pop fire.
REQ-014 resp push enable = resp FIFO[resp_push_ch] not full; resp_push_ch sampled in fire cycle.
REQ-015 Response fired for channel with outstanding=0 shall be discarded (not written), still acked, and set resp_err until reset.
REQ-016 resp pop enable(c) = resp FIFO c non-empty; resp_pop_data slice c registered at fire edge, held until next pop on c.
REQ-017 outstanding(c): +1 on cmd push fire c, -1 on resp pop fire c, unchanged on both same cycle; never exceeds RESP_DEPTH.
REQ-018 Simultaneous push and pop on the same FIFO in one cycle shall both complete; occupancy unchanged.
REQ-019 Pointers wrap mod depth; full/empty shall use depth+1-bit occupancy, no entry lost at wrap.
REQ-020 resp_pop_ready(c) = resp FIFO c non-empty, combinational from registered state.

Reset
REQ-021 reset=1 at a clock edge: all FSMs ->IDLE, all FIFOs empty, pointers 0, outstanding=0, round-robin pointer to channel 0, resp_err=0, all acks 0, pop data/ch outputs 0.
REQ-022 Reset mid-handshake shall abort it; a req still high after reset shall not fire until it falls and rises again.

Verification
REQ-023 Push 0xA1,0xA2 on ch0, 0xB1 on ch1, three cmd pops -> cmd_pop_data/ch = A1/0, B1/1, A2/0; outstanding = 2,1.
REQ-024 ch0 pushes with no pops: RESP_DEPTH=4 -> 4th push acks, 5th stays in WAIT, ack=0; after one resp push+pop on ch0, 5th fires.
REQ-025 resp_push_ch=1 with outstanding(1)=0 -> resp_push_ack=1, resp_pop_ready[1]=0, resp_err=1.
REQ-026 req held high 10 cycles -> exactly one fire; ack high cycles N+2..until req falls.
REQ-027 cmd push and cmd pop fire same cycle on ch0 with 1 entry -> occupancy stays 1, popped value is the old head.
REQ-028 reset asserted while cmd_push_req[0] in WAIT -> FIFO empty, ack 0; req kept high after reset -> no fire.
